envelope_gen: RTL and testbench

- Amplitude-envelope stage between the SPI register block and the amplitude x volume multiplier.
- Converts the raw per-packet volume into a smoothed attack/decay/sustain/release envelope, so note starts, stops and changes are click-free.
- Advances only on the wave-generator strobe (156.25 kHz, one cycle in 256 at 40 MHz).
- Its output replaces the volume register that feeds the multiplier.

---
 rtl/envelope_gen.sv | 178 +++++++++++++++++
 tb/tb_envelope_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/envelope_gen.sv
// envelope_gen: attack/decay/sustain/release amplitude envelope.
// Sits between the SPI register block and the amplitude x volume multiplier.
// It smooths the raw per-packet volume so that note starts, stops and changes
// do not click. The envelope advances only on the wave-generator tick strobe.
//
// Build option: define ENV_HARD_RETRIGGER_EN to force envVol to 0 on every
// note-on/retrigger (hard attack). The default build keeps the current level
// on retrigger (soft attack).
module envelope_gen #(
  parameter int ATTACK_DIV  = 4,    // ticks per +1 step in ATTACK (1..255)
  parameter int DECAY_DIV   = 16,   // ticks per -1 step in DECAY (1..255)
  parameter int RELEASE_DIV = 32,   // ticks per -1 step in RELEASE (1..255)
  parameter int SUSTAIN_NUM = 192   // sustain = volume*SUSTAIN_NUM/256 (0..255)
) (
  input  logic        clk,
  input  logic        reset,        // synchronous, active low
  input  logic        tick,
  input  logic [15:0] tuneWord,
  input  logic [7:0]  volume,
  output logic [7:0]  envVol,
  output logic        noteActive,
  output logic [2:0]  envState
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } envStateT;

  localparam logic [7:0]  ATTACK_LAST  = 8'(ATTACK_DIV - 1);
  localparam logic [7:0]  DECAY_LAST   = 8'(DECAY_DIV - 1);
  localparam logic [7:0]  RELEASE_LAST = 8'(RELEASE_DIV - 1);
  localparam logic [15:0] SUS_NUM16    = 16'(SUSTAIN_NUM);

`ifdef ENV_HARD_RETRIGGER_EN
  localparam logic HARD_RETRIGGER = 1'b1;
`else
  localparam logic HARD_RETRIGGER = 1'b0;
`endif

  envStateT    stateReg, stateNext;
  logic [7:0]  envVolReg, envVolNext;
  logic [7:0]  prescReg, prescNext;
  logic [15:0] tuneReg, tuneNext;

  // Levels derived from the live inputs.
  logic [7:0]  peak;
  logic [15:0] susProd;
  logic [7:0]  sus;
  logic        noteOff;
  logic        noteOn;
  logic [7:0]  stepLast;
  logic        stepHit;

  assign peak    = volume;
  assign susProd = {8'd0, volume} * SUS_NUM16;
  assign sus     = susProd[15:8];

  // A note-off only matters while a note is sounding; a note-on is either a
  // fresh start or a change to a different (non-zero) frequency word.
  assign noteOff = (tuneWord == 16'd0) && (stateReg != IDLE) && (stateReg != RELEASE);
  assign noteOn  = (tuneWord != 16'd0) &&
                   ((stateReg == IDLE) || (stateReg == RELEASE) || (tuneWord != tuneReg));

  // Pick the prescaler terminal count for the current state.
  always_comb begin
    stepLast = 8'd0;
    case (stateReg)
      ATTACK:  stepLast = ATTACK_LAST;
      DECAY:   stepLast = DECAY_LAST;
      RELEASE: stepLast = RELEASE_LAST;
      default: stepLast = 8'd0;
    endcase
  end

  assign stepHit = (prescReg == stepLast);

  // State register: reset overrides everything, otherwise update only on tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg  <= IDLE;
      envVolReg <= 8'd0;
      prescReg  <= 8'd0;
      tuneReg   <= 16'd0;
    end else if (tick) begin
      stateReg  <= stateNext;
      envVolReg <= envVolNext;
      prescReg  <= prescNext;
      tuneReg   <= tuneNext;
    end
  end

  // Next-state logic: note-off, then note-on/retrigger, then per-state progression.
  always_comb begin
    stateNext  = stateReg;
    envVolNext = envVolReg;
    prescNext  = prescReg;
    tuneNext   = tuneReg;

    if (noteOff) begin
      stateNext = RELEASE;
      prescNext = 8'd0;
    end else if (noteOn) begin
      stateNext  = ATTACK;
      prescNext  = 8'd0;
      tuneNext   = tuneWord;
      envVolNext = HARD_RETRIGGER ? 8'd0 : envVolReg;
    end else begin
      case (stateReg)
        IDLE: begin
          envVolNext = 8'd0;
          prescNext  = 8'd0;
        end
        ATTACK: begin
          // Checked before stepping, so a lowered peak or a zero volume
          // moves on at once with the level clamped to peak.
          if (envVolReg >= peak) begin
            envVolNext = peak;
            stateNext  = DECAY;
            prescNext  = 8'd0;
          end else if (stepHit) begin
            envVolNext = envVolReg + 8'd1;  // cannot pass peak: envVolReg < peak
            prescNext  = 8'd0;
          end else begin
            prescNext = prescReg + 8'd1;
          end
        end
        DECAY: begin
          if (envVolReg <= sus) begin
            envVolNext = sus;
            stateNext  = SUSTAIN;
            prescNext  = 8'd0;
          end else if (stepHit) begin
            envVolNext = envVolReg - 8'd1;  // envVolReg > sus >= 0, no underflow
            prescNext  = 8'd0;
          end else begin
            prescNext = prescReg + 8'd1;
          end
        end
        SUSTAIN: begin
          // Glide one step per tick toward the live sustain level.
          prescNext = 8'd0;
          if (envVolReg > sus) begin
            envVolNext = envVolReg - 8'd1;
          end else if (envVolReg < sus) begin
            envVolNext = envVolReg + 8'd1;
          end
        end
        RELEASE: begin
          if (envVolReg == 8'd0) begin
            stateNext = IDLE;
            tuneNext  = 16'd0;
            prescNext = 8'd0;
          end else if (stepHit) begin
            envVolNext = envVolReg - 8'd1;
            prescNext  = 8'd0;
          end else begin
            prescNext = prescReg + 8'd1;
          end
        end
        default: begin
          stateNext  = IDLE;
          envVolNext = 8'd0;
          prescNext  = 8'd0;
          tuneNext   = 16'd0;
        end
      endcase
    end
  end

  assign envVol     = envVolReg;
  assign envState   = stateReg;
  assign noteActive = (stateReg != IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// tb_envelope_gen: table-driven ADSR walk plus hand-written corner sequences.
// Ticks are spaced two clocks apart to keep long envelopes short in cycles.
module tb_envelope_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [15:0] tuneWord;
  logic [7:0]  volume;
  logic [7:0]  envVol;
  logic        noteActive;
  logic [2:0]  envState;

  int checks = 0;
  int errors = 0;

  envelope_gen dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .tuneWord   (tuneWord),
    .volume     (volume),
    .envVol     (envVol),
    .noteActive (noteActive),
    .envState   (envState)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tw;
    logic [7:0]  vol;
    int          nTicks;
    logic [7:0]  expVol;
    logic [2:0]  expState;
  } vecT;

  vecT vecs[14];

`ifdef ENV_HARD_RETRIGGER_EN
  localparam int RETRIG_START = 0;
`else
  localparam int RETRIG_START = 96;
`endif

  // Compare all outputs against expectations; called at a negedge.
  task automatic check(input string name, input logic [7:0] expVol, input logic [2:0] expState);
    logic expAct;
    expAct = (expState != 3'd0);
    checks++;
    if (envVol !== expVol || envState !== expState || noteActive !== expAct) begin
      errors++;
      $display("FAIL %s: got envVol=%0d envState=%0d noteActive=%0b, expected envVol=%0d envState=%0d noteActive=%0b",
               name, envVol, envState, noteActive, expVol, expState, expAct);
    end else begin
      $display("ok   %s: envVol=%0d envState=%0d noteActive=%0b", name, envVol, envState, noteActive);
    end
  endtask

  // Issue n tick strobes, one clock high and one clock low each; ends on a negedge.
  task automatic doTicks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int relStart;
    reset    = 1'b0;
    tick     = 1'b0;
    tuneWord = 16'h1234;
    volume   = 8'hFF;

    // Reset held with tick pulsing and a live note request.
    for (int i = 0; i < 3; i++) begin
      tick = (i % 2 == 0);
      @(negedge clk);
      check($sformatf("reset_hold_%0d", i), 8'd0, 3'd0);
    end
    tick     = 1'b0;
    tuneWord = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("after_reset_release", 8'd0, 3'd0);

    // Full ADSR with default parameters: peak 128, sustain 96.
    vecs[0]  = '{16'h0400, 8'h80, 1,    8'd0,   3'd1};  // note-on
    vecs[1]  = '{16'h0400, 8'h80, 4,    8'd1,   3'd1};  // first attack step
    vecs[2]  = '{16'h0400, 8'h80, 507,  8'd127, 3'd1};
    vecs[3]  = '{16'h0400, 8'h80, 1,    8'd128, 3'd1};  // 512 ticks: at peak
    vecs[4]  = '{16'h0400, 8'h80, 1,    8'd128, 3'd2};  // -> DECAY
    vecs[5]  = '{16'h0400, 8'h80, 16,   8'd127, 3'd2};
    vecs[6]  = '{16'h0400, 8'h80, 496,  8'd96,  3'd2};  // 512 decay ticks
    vecs[7]  = '{16'h0400, 8'h80, 1,    8'd96,  3'd3};  // -> SUSTAIN
    vecs[8]  = '{16'h0400, 8'h80, 5,    8'd96,  3'd3};
    vecs[9]  = '{16'h0000, 8'h80, 1,    8'd96,  3'd4};  // note-off
    vecs[10] = '{16'h0000, 8'h80, 32,   8'd95,  3'd4};
    vecs[11] = '{16'h0000, 8'h80, 3040, 8'd0,   3'd4};  // 96*32 release ticks
    vecs[12] = '{16'h0000, 8'h80, 1,    8'd0,   3'd0};  // -> IDLE
    vecs[13] = '{16'h0000, 8'h80, 3,    8'd0,   3'd0};

    for (int i = 0; i < 14; i++) begin
      tuneWord = vecs[i].tw;
      volume   = vecs[i].vol;
      doTicks(vecs[i].nTicks);
      check($sformatf("vec_%0d", i), vecs[i].expVol, vecs[i].expState);
    end

    // Back to SUSTAIN at 96, then lower the volume: sus drops to 48.
    tuneWord = 16'h0400;
    volume   = 8'h80;
    doTicks(1027);
    check("sustain_reached", 8'd96, 3'd3);
    volume = 8'h40;
    for (int k = 1; k <= 48; k++) begin
      doTicks(1);
      check($sformatf("sus_track_%0d", k), 8'(96 - k), 3'd3);
    end
    doTicks(5);
    check("sus_track_hold", 8'd48, 3'd3);

    // Same tuneWord with a higher volume: no retrigger, glide back up.
    volume = 8'h80;
    doTicks(48);
    check("sus_track_up", 8'd96, 3'd3);

    // Retrigger by a new tuneWord.
    tuneWord = 16'h0500;
    doTicks(1);
    check("retrigger", 8'(RETRIG_START), 3'd1);
    doTicks(4);
    check("retrigger_step", 8'(RETRIG_START + 1), 3'd1);

    // Note-off while a note is sounding: RELEASE, level held.
    relStart = RETRIG_START + 1;
    tuneWord = 16'h0000;
    doTicks(1);
    check("noteoff_release", 8'(relStart), 3'd4);
    doTicks(relStart * 32);
    check("release_zero", 8'd0, 3'd4);
    doTicks(1);
    check("release_idle", 8'd0, 3'd0);

    // volume 0: ATTACK, DECAY, SUSTAIN with the level pinned at 0.
    tuneWord = 16'h0600;
    volume   = 8'h00;
    doTicks(1);
    check("vol0_attack", 8'd0, 3'd1);
    doTicks(1);
    check("vol0_decay", 8'd0, 3'd2);
    doTicks(1);
    check("vol0_sustain", 8'd0, 3'd3);
    doTicks(1);
    check("vol0_sustain_hold", 8'd0, 3'd3);
    tuneWord = 16'h0000;
    doTicks(1);
    check("vol0_release", 8'd0, 3'd4);
    doTicks(1);
    check("vol0_idle", 8'd0, 3'd0);

    // tick low for 1000 cycles freezes everything, even with inputs changing.
    tuneWord = 16'h0700;
    volume   = 8'hFF;
    doTicks(21);
    check("pre_freeze", 8'd5, 3'd1);
    tuneWord = 16'h0000;
    volume   = 8'h00;
    repeat (1000) @(negedge clk);
    check("freeze", 8'd5, 3'd1);
    tuneWord = 16'h0700;
    volume   = 8'hFF;

    // Mid-operation reset during ATTACK at level 50.
    doTicks(180);
    check("attack_50", 8'd50, 3'd1);
    reset = 1'b0;
    tick  = 1'b1;
    @(negedge clk);
    check("mid_reset", 8'd0, 3'd0);
    reset = 1'b1;
    tick  = 1'b0;
    @(negedge clk);
    doTicks(1);
    check("fresh_attack", 8'd0, 3'd1);
    doTicks(4);
    check("fresh_attack_step", 8'd1, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
